// File: rtl/split_a_and_b_using_fifos.sv
// Splits a packed {a,b} upstream stream into two independently drained
// flip-flop FIFOs; an upstream word is taken only when both sides have room.

module split_fifo #(
    parameter int width = 8,
    parameter int depth = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [width-1:0] din,
    input  logic             pop_ready,
    output logic             valid,
    output logic [width-1:0] dout,
    output logic             full
);
    localparam int PTR_W = (depth > 1) ? $clog2(depth) : 1;
    localparam int CNT_W = $clog2(depth + 1);

    logic [width-1:0] mem [depth];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             pop;

    // Pointers wrap explicitly so depth need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign valid = (count != '0);
    assign full  = (count == CNT_W'(depth));
    assign pop   = valid & pop_ready;
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < depth; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module split_a_and_b_using_fifos #(
    parameter int width = 8,
    parameter int depth = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               up_valid,
    output logic               up_ready,
    input  logic [2*width-1:0] up_data,
    output logic               a_valid,
    input  logic               a_ready,
    output logic [width-1:0]   a_data,
    output logic               b_valid,
    input  logic               b_ready,
    output logic [width-1:0]   b_data
);
    localparam int NUM_LANES = 2;  // lane 1 = a, lane 0 = b

    logic [NUM_LANES-1:0][width-1:0] lane_din, lane_dout;
    logic [NUM_LANES-1:0]            lane_rdy, lane_vld, lane_full;
    logic                            push;

    // up_ready comes only from FIFO state so it never depends on up_valid.
    assign up_ready = ~|lane_full;
    assign push     = up_valid & up_ready;
    assign lane_din = up_data;
    assign lane_rdy = {a_ready, b_ready};

    generate
        for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
            split_fifo #(.width(width), .depth(depth)) u_fifo (
                .clk       (clk),
                .rst       (rst),
                .push      (push),
                .din       (lane_din[l]),
                .pop_ready (lane_rdy[l]),
                .valid     (lane_vld[l]),
                .dout      (lane_dout[l]),
                .full      (lane_full[l])
            );
        end
    endgenerate

    assign a_valid = lane_vld[1];
    assign a_data  = lane_dout[1];
    assign b_valid = lane_vld[0];
    assign b_data  = lane_dout[0];
endmodule

// File: tb/tb_split_a_and_b_using_fifos.sv
// Scoreboard bench for split_a_and_b_using_fifos: stimulus queues expected
// a/b elements on acceptance, a negedge monitor checks every pop.

module tb_split_a_and_b_using_fifos;
    localparam int W = 8;
    localparam int D = 10;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           up_valid = 1'b0;
    logic           up_ready;
    logic [2*W-1:0] up_data = '0;
    logic           a_valid, b_valid;
    logic           a_ready = 1'b0, b_ready = 1'b0;
    logic [W-1:0]   a_data, b_data;

    int errs = 0;
    int checks = 0;
    logic [W-1:0] qa[$];
    logic [W-1:0] qb[$];

    split_a_and_b_using_fifos #(.width(W), .depth(D)) dut (
        .clk(clk), .rst(rst),
        .up_valid(up_valid), .up_ready(up_ready), .up_data(up_data),
        .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Entered 1 time unit after a rising edge; returns 1 unit after the next.
    task automatic cycle(input logic v, input logic [2*W-1:0] d, input logic ar,
                         input logic br, output logic acc);
        up_valid = v; up_data = d; a_ready = ar; b_ready = br;
        #2;
        acc = v && up_ready;
        if (acc) begin
            qa.push_back(d[2*W-1:W]);
            qb.push_back(d[W-1:0]);
        end
        @(posedge clk); #1;
    endtask

    task automatic drain();
        logic acc;
        int n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < 40) begin
            cycle(1'b0, '0, 1'b1, 1'b1, acc);
            n++;
        end
        chk("drain_a_left", qa.size(), 0);
        chk("drain_b_left", qb.size(), 0);
    endtask

    // Monitor: the queues hold this cycle's pending push, so back it out
    // to get the occupancy the DUT holds right now.
    always @(negedge clk) begin
        int occ_a, occ_b, pend;
        if (!rst) begin
            pend  = (up_valid && up_ready) ? 1 : 0;
            occ_a = qa.size() - pend;
            occ_b = qb.size() - pend;
            chk("up_ready_vs_occ", up_ready, (occ_a < D && occ_b < D));
            chk("a_valid_vs_occ", a_valid, (occ_a != 0));
            chk("b_valid_vs_occ", b_valid, (occ_b != 0));
            if (a_valid && a_ready) begin
                if (qa.size() == 0) chk("a_unexpected_pop", 1, 0);
                else chk("a_data", a_data, qa.pop_front());
            end
            if (b_valid && b_ready) begin
                if (qb.size() == 0) chk("b_unexpected_pop", 1, 0);
                else chk("b_data", b_data, qb.pop_front());
            end
        end
    end

    initial begin
        logic acc;
        int   n, cyc;

        // Reset state
        #3;
        chk("rst_a_valid", a_valid, 0);
        chk("rst_b_valid", b_valid, 0);
        chk("rst_up_ready", up_ready, 1);
        chk("rst_a_data", a_data, 0);
        chk("rst_b_data", b_data, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // 1: single word, one cycle latency
        cycle(1'b1, 16'hA55A, 1'b1, 1'b1, acc);
        chk("t1_acc", acc, 1);
        chk("t1_a_valid", a_valid, 1);
        chk("t1_b_valid", b_valid, 1);
        chk("t1_a_data", a_data, 8'hA5);
        chk("t1_b_data", b_data, 8'h5A);
        cycle(1'b0, '0, 1'b1, 1'b1, acc);
        chk("t1_a_valid_after", a_valid, 0);
        chk("t1_b_valid_after", b_valid, 0);

        // 2: a stalled, 11 offered, 10 fit
        n = 0;
        for (int i = 0; i < 11; i++) begin
            cycle(1'b1, 16'h2000 + 16'(i * 16'h0101), 1'b0, 1'b1, acc);
            if (acc) n++;
        end
        chk("t2_accepted", n, 10);
        chk("t2_up_ready_full", up_ready, 0);
        for (int i = 0; i < 12; i++) cycle(1'b0, '0, 1'b0, 1'b1, acc);
        chk("t2_a_holds", a_valid, 1);
        chk("t2_b_empty", b_valid, 0);
        chk("t2_a_head", a_data, 8'h20);
        cycle(1'b1, 16'hEEEE, 1'b1, 1'b1, acc);  // full a pops: still no push
        chk("t2_full_pop_no_push", acc, 0);
        drain();

        // 3: streaming 25 words, pointers wrap twice
        n = 0; cyc = 0;
        while (n < 25 && cyc < 100) begin
            cycle(1'b1, 16'h0100 + 16'(n * 16'h0101), 1'b1, 1'b1, acc);
            if (acc) n++;
            cyc++;
        end
        chk("t3_accepted", n, 25);
        drain();

        // 4: a at 5 entries, push+pop same cycle keeps occupancy
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, {8'(8'h40 + i), 8'(8'h50 + i)}, 1'b0, 1'b1, acc);
            chk("t4_fill_acc", acc, 1);
        end
        chk("t4_head0", a_data, 8'h40);
        cycle(1'b1, 16'h4555, 1'b1, 1'b1, acc);
        chk("t4_pushpop_acc", acc, 1);
        chk("t4_head1", a_data, 8'h41);
        n = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 16'h4600 + 16'(i), 1'b0, 1'b1, acc);
            if (acc) n++;
        end
        chk("t4_room_left", n, 5);
        drain();

        // 5: reset asserted mid-cycle with 4 words buffered
        for (int i = 0; i < 4; i++) cycle(1'b1, 16'h7000 + 16'(i), 1'b0, 1'b0, acc);
        chk("t5_a_valid_pre", a_valid, 1);
        up_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("t5_a_valid_rst", a_valid, 0);
        chk("t5_b_valid_rst", b_valid, 0);
        chk("t5_up_ready_rst", up_ready, 1);
        chk("t5_a_data_rst", a_data, 0);
        qa.delete(); qb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b1, acc);
        chk("t5_a_valid_post", a_valid, 0);
        chk("t5_b_valid_post", b_valid, 0);

        // 6: random handshakes, 1000 words
        n = 0; cyc = 0;
        while (n < 1000 && cyc < 20000) begin
            cycle(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), acc);
            if (acc) n++;
            cyc++;
        end
        chk("t6_accepted", n, 1000);
        drain();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
